multicycle_datapath: RTL

Datapath half of the multicycle RV32I core. It consumes the per-cycle control signals from the multicycle controller and returns the instruction fields and ALU Zero flag that the controller decodes. It holds the architectural state (PC, register file) and the non-architectural registers (OldPC, Instr, Data, A, B, ALUOut). It talks to a single unified instruction/data memory through one address port.

---
 rtl/multicycle_datapath.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// ============================================================================
//  Module   : multicycle_datapath
//  Purpose  : RV32I multicycle datapath (PC, register file, ALU, state regs)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ImmSrc,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ResultSrc,
    input  logic        AdrSrc,
    input  logic [2:0]  ALUControl,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic [31:0] ReadData,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        Zero,
    output logic [31:0] Adr,
    output logic [31:0] WriteData
);

    logic [31:0] pc_q,     pc_d;
    logic [31:0] oldpc_q,  oldpc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] data_q,   data_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic [31:0] aluout_q, aluout_d;

    logic [31:0] rf_q [32];

    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rd1, w_rd2;
    logic [31:0] w_imm_ext;
    logic [31:0] w_src_a, w_src_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_result;

    assign w_rs1 = instr_q[19:15];
    assign w_rs2 = instr_q[24:20];
    assign w_rd  = instr_q[11:7];

    // x0 is hardwired to zero on the read side; writes to it are dropped below.
    assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 : rf_q[w_rs1];
    assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 : rf_q[w_rs2];

    always_comb begin
        w_imm_ext = 32'd0;
        case (ImmSrc)
            2'b00: w_imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            2'b01: w_imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            2'b10: w_imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                instr_q[30:25], instr_q[11:8], 1'b0};
            2'b11: w_imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                instr_q[20], instr_q[30:21], 1'b0};
            default: w_imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        w_src_a = 32'd0;
        case (ALUSrcA)
            2'b00:   w_src_a = pc_q;
            2'b01:   w_src_a = oldpc_q;
            2'b10:   w_src_a = a_q;
            default: w_src_a = 32'd0;
        endcase
    end

    always_comb begin
        w_src_b = 32'd0;
        case (ALUSrcB)
            2'b00:   w_src_b = b_q;
            2'b01:   w_src_b = w_imm_ext;
            2'b10:   w_src_b = 32'd4;
            default: w_src_b = 32'd0;
        endcase
    end

    always_comb begin
        w_alu_result = 32'd0;
        case (ALUControl)
            3'b000:  w_alu_result = w_src_a + w_src_b;
            3'b001:  w_alu_result = w_src_a - w_src_b;
            3'b010:  w_alu_result = w_src_a & w_src_b;
            3'b011:  w_alu_result = w_src_a | w_src_b;
            3'b101:  w_alu_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
            default: w_alu_result = 32'd0;
        endcase
    end

    always_comb begin
        w_result = 32'd0;
        case (ResultSrc)
            2'b00:   w_result = aluout_q;
            2'b01:   w_result = data_q;
            2'b10:   w_result = w_alu_result;
            default: w_result = 32'd0;
        endcase
    end

    // OldPC takes the pre-edge PC so a fetch cycle can advance PC at the same time.
    always_comb begin
        pc_d     = PCWrite ? w_result : pc_q;
        oldpc_d  = IRWrite ? pc_q     : oldpc_q;
        instr_d  = IRWrite ? ReadData : instr_q;
        data_d   = ReadData;
        a_d      = w_rd1;
        b_d      = w_rd2;
        aluout_d = w_alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= 32'd0;
            instr_q  <= 32'd0;
            data_q   <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && RegWrite && (w_rd != 5'd0)) begin
            rf_q[w_rd] <= w_result;
        end
    end

    assign op        = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7b5  = instr_q[30];
    assign Zero      = (w_alu_result == 32'd0);
    assign Adr       = AdrSrc ? w_result : pc_q;
    assign WriteData = b_q;

endmodule

`default_nettype wire
